fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single write port of the single-clock FIFO among NREQ producers.
//  Producers use a valid/ready handshake. Grants are held for a burst of up to MAX_BURST beats.
//  Drives the FIFO's buf_in/wr_en from registers, and gates acceptance on fifo_counter so the FIFO never overflows.
// PARAMETERS
//  NREQ       4    number of requesters (2..8)
//  DW         8    data width; matches FIFO buf_in
//  DEPTH      64   FIFO capacity in words
//  CW         8    width of fifo_counter
//  MAX_BURST  4    max beats per grant (>=1)
// PORTS
//  clk          in   1        clock, all logic on rising edge
//  rst          in   1        asynchronous, active-low reset (0 = reset)
//  req_valid    in   NREQ     per-requester data valid
//  req_last     in   NREQ     per-requester last beat of burst; qualified by valid
//  req_data     in   NREQ*DW  requester i data at [i*DW +: DW]
//  req_ready    out  NREQ     one-hot (or 0); beat accepted when valid&ready
//  fifo_counter in   CW       FIFO occupancy
//  buf_in       out  DW       FIFO write data (registered)
//  wr_en        out  1        FIFO write enable (registered)
//  grant        out  NREQ     one-hot current owner (registered), 0 in IDLE
//  busy         out  1        1 while in GRANT state
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, wr_en=0, buf_in=0, busy=0.
//   Reset mid-burst abandons the burst; no partial word is written after reset asserts.
//  FSM IDLE:
//   - If any req_valid: pick the first index i >= rr_ptr (wrapping mod NREQ) with valid.
//   - Register grant=1<<i, beat_cnt=0, go GRANT. Arbitration latency is 1 cycle.
//   - req_ready=0 in IDLE.
//  FSM GRANT (owner g):
//   - space = (fifo_counter + wr_en) < DEPTH, computed at CW+1 bits. The in-flight registered write is counted.
//   - req_ready[g] = space; all other ready bits are 0.
//   - xfer = req_valid[g] & req_ready[g]. On xfer: buf_in<=req_data[g], wr_en<=1, beat_cnt++. Otherwise wr_en<=0.
//   - Release (next state IDLE, rr_ptr<=(g+1)%NREQ, grant<=0) on any of:
//     (a) xfer & req_last[g]
//     (b) xfer & beat_cnt==MAX_BURST-1
//     (c) !req_valid[g]: owner withdrew; no write that cycle
//   - FIFO full (space=0): hold grant, ready=0, no timeout. The burst resumes when space returns.
//  Latency: accepted beat appears on wr_en/buf_in exactly 1 cycle after the xfer edge.
//  Fairness: after release, at least one IDLE cycle follows. Every waiting requester is granted within NREQ grants.
//  Back-to-back: release and new arbitration never overlap. Max throughput is MAX_BURST beats per MAX_BURST+1 cycles.
//  Invariant: the FIFO count never exceeds DEPTH. wr_en is never 1 while the FIFO is full (checked by assertion).
//  req_data of non-owners is ignored. req_last is ignored when valid=0.
// STRUCTURE
//  Package fifo_arb_pkg:
//   - state typedef {IDLE, GRANT}
//   - function rr_pick(valid, ptr) returning a one-hot grant
//   - localparam BCW=$clog2(MAX_BURST+1)
//  Sub-module rr_arbiter_core: combinational rotate / priority-encode / rotate-back from valid+rr_ptr.
//   The FSM, counters and output registers stay in fifo_wr_arbiter.
//  Top-level test wraps fifo_wr_arbiter + FIFO (DEPTH=64) so occupancy is real.
// TESTING
//  1) Reset: rst=0 mid-run with req_valid=4'b1111.
//     -> wr_en=0, grant=0, busy=0 asynchronously. The first grant after release goes to req0.
//  2) Round-robin: all 4 valid continuously, no last, MAX_BURST=4.
//     -> grants in order 0,1,2,3,0. Each holds 4 writes. 1 idle cycle between grants.
//  3) Early last: req1 sends 0xA0,0xA1 with last on 0xA1, req2 valid.
//     -> FIFO receives A0,A1, then req2 data. rr_ptr=2 after release.
//  4) Full backpressure: preload the FIFO to 63, req0 sends 3 beats.
//     -> one beat written, ready=0 while count=64. Writes resume after a FIFO read; no overflow, no data loss.
//  5) Withdraw: req3 granted, drops valid before any beat.
//     -> no write, release next cycle, next grant goes to req0.
//  6) Ordering check: random valid/last/reads over 10k cycles. A scoreboard per source confirms:
//     -> FIFO output is in-order per requester, no loss or duplicate, wr_en never with count=64.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// rr_pick is a loop-based reference pick that cross-checks the rotate-based core.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Beat counter is sized for bursts of up to BURST_LIM beats.
  localparam int BURST_LIM = 15;
  localparam int BCW       = $clog2(BURST_LIM + 1);

  function automatic logic [7:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int         nreq);
    logic [7:0] g;
    logic       found;
    int         idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k < nreq && !found) begin
        idx = (int'(ptr) + k) % nreq;
        if (valid[idx]) begin
          g[idx] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin pick: rotate valid by ptr, keep the lowest set bit,
// rotate the one-hot result back into requester order.
module rr_arbiter_core #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] pick;

  assign rot   = NREQ'({valid, valid} >> ptr);
  assign pick  = rot & (~rot + NREQ'(1));
  assign grant = NREQ'(({pick, pick} << ptr) >> NREQ);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers,
// with bounded bursts and occupancy-based backpressure that counts the in-flight write.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int DEPTH     = 64,
  parameter int CW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_last,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  input  logic [CW-1:0]    fifo_counter,
  output logic [DW-1:0]    buf_in,
  output logic             wr_en,
  output logic [NREQ-1:0]  grant,
  output logic             busy
);

  localparam int             PW        = $clog2(NREQ);
  localparam logic [CW:0]    DEPTH_C   = (CW+1)'(DEPTH);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] grant_d;
  logic [NREQ-1:0] pick;
  logic [PW-1:0]   rr_ptr, rr_ptr_d;
  logic [PW-1:0]   owner_idx;
  logic [BCW-1:0]  beat_cnt, beat_d;
  logic            wr_en_d;
  logic [DW-1:0]   buf_d;
  logic [DW-1:0]   owner_data;
  logic            owner_valid;
  logic            owner_last;
  logic            space;
  logic            xfer;
  logic            rel;
  logic [7:0]      ref_pick;

  rr_arbiter_core #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_core (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick)
  );

  assign owner_valid = |(req_valid & grant);
  assign owner_last  = |(req_last & grant);

  always_comb begin
    owner_idx  = '0;
    owner_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        owner_idx  = PW'(i);
        owner_data = req_data[i*DW +: DW];
      end
    end
  end

  // The registered write not yet seen in fifo_counter still occupies a slot.
  assign space     = ({1'b0, fifo_counter} + (CW+1)'(wr_en)) < DEPTH_C;
  assign busy      = (state_q == GRANT);
  assign req_ready = (busy && space) ? grant : '0;
  assign xfer      = busy & owner_valid & space;
  assign rel       = busy & (~owner_valid | (xfer & (owner_last | (beat_cnt == LAST_BEAT))));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant;
    rr_ptr_d = rr_ptr;
    beat_d   = beat_cnt;
    wr_en_d  = 1'b0;
    buf_d    = buf_in;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          wr_en_d = 1'b1;
          buf_d   = owner_data;
          beat_d  = beat_cnt + BCW'(1);
        end
        if (rel) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (owner_idx == PW'(NREQ - 1)) ? '0 : owner_idx + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- state / output register stage ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      wr_en    <= 1'b0;
      buf_in   <= '0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      rr_ptr   <= rr_ptr_d;
      beat_cnt <= beat_d;
      wr_en    <= wr_en_d;
      buf_in   <= buf_d;
    end
  end

  assign ref_pick = rr_pick(8'(req_valid), 3'(rr_ptr), NREQ);

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    wr_en |-> ({1'b0, fifo_counter} < DEPTH_C));

  a_pick_matches_ref : assert property (@(posedge clk) disable iff (!rst)
    (state_q == IDLE) |-> (ref_pick == 8'(pick)));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter driving a behavioural 64-deep FIFO.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int DEPTH     = 64;
  localparam int CW        = 8;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_last  = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic [CW-1:0]     fifo_cnt;
  logic [DW-1:0]     buf_in;
  logic              wr_en;
  logic [NREQ-1:0]   grant;
  logic              busy;

  logic rd_en    = 1'b0;
  logic clr      = 1'b1;
  logic pre_push = 1'b0;
  logic sb_en    = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]   q[$];
  logic [DW-1:0]   wlog[$];
  int              acc_n[NREQ];
  int              pop_n[NREQ];
  logic [NREQ-1:0] acc_q;
  logic [DW-1:0]   pop_d;
  int              pop_src;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .DW        (DW),
    .DEPTH     (DEPTH),
    .CW        (CW),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_counter (fifo_cnt),
    .buf_in       (buf_in),
    .wr_en        (wr_en),
    .grant        (grant),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural FIFO plus per-source acceptance and in-order scoreboard.
  always @(posedge clk) begin
    if (clr) begin
      q.delete();
      acc_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        acc_n[i] <= 0;
        pop_n[i] = 0;
      end
    end else begin
      acc_q <= req_valid & req_ready;
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] & req_ready[i]) acc_n[i] <= acc_n[i] + 1;
      if (wr_en) chk("no_ovf", 32'(q.size() < DEPTH), 32'd1);
      if (rd_en && q.size() > 0) begin
        pop_d = q.pop_front();
        if (sb_en) begin
          pop_src = int'(pop_d[7:6]);
          chk("order", 32'(pop_d[5:0]), 32'(pop_n[pop_src] % 64));
          pop_n[pop_src]++;
        end
      end
      if (wr_en) begin
        q.push_back(buf_in);
        if (!sb_en) wlog.push_back(buf_in);
      end
      if (pre_push) q.push_back(8'hEE);
    end
    fifo_cnt <= CW'(q.size());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b0; clr = 1'b1; sb_en = 1'b0;
    req_valid = '0; req_last = '0; rd_en = 1'b0; pre_push = 1'b0;
    tick();
    tick();
    rst = 1'b1; clr = 1'b0;
    wlog.delete();
  endtask

  logic [NREQ-1:0] ghist[1:21];
  int              wcnt;
  int              kk[9]  = '{1, 5, 6, 10, 11, 15, 16, 20, 21};
  int              gexp[9] = '{1, 0, 2, 0, 4, 0, 8, 0, 1};
  int              pcts[4] = '{50, 15, 90, 30};
  int              rd_pct;
  logic            v;
  logic [DW-1:0]   a4[4] = '{8'hA0, 8'hA1, 8'hC0, 8'hA2};

  initial begin
    // Test 1: reset values, async reset mid-burst, first grant afterwards
    tick();
    tick();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_buf_in", 32'(buf_in), 32'd0);
    rst = 1'b1; clr = 1'b0;
    for (int i = 0; i < NREQ; i++) set_data(i, DW'(8'h10 * i));
    req_valid = 4'hF;
    tick();
    chk("t1_grant0", 32'(grant), 32'd1);
    tick();
    chk("t1_wr_before_rst", 32'(wr_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t1_async_wr_en", 32'(wr_en), 32'd0);
    chk("t1_async_grant", 32'(grant), 32'd0);
    chk("t1_async_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick();
    chk("t1_first_grant", 32'(grant), 32'd1);
    chk("t1_no_partial", 32'(wlog.size()), 32'd0);

    // Test 2: all requesters valid, no last, full bursts in round-robin order
    do_reset();
    req_valid = 4'hF;
    wcnt = 0;
    for (int k = 1; k <= 21; k++) begin
      tick();
      ghist[k] = grant;
      if (k <= 20 && wr_en) wcnt++;
    end
    req_valid = '0;
    for (int j = 0; j < 9; j++) chk("t2_grant_seq", 32'(ghist[kk[j]]), 32'(gexp[j]));
    chk("t2_write_cnt", 32'(wcnt), 32'd16);
    chk("t2_log_size", 32'(wlog.size()), 32'd16);
    if (wlog.size() == 16)
      for (int j = 0; j < 16; j++) chk("t2_log_data", 32'(wlog[j]), 32'(8'h10 * (j / 4)));

    // Test 3: early last from req1, pointer moves past it
    do_reset();
    set_data(1, 8'hA0);
    set_data(2, 8'hC0);
    req_last  = 4'b0100;
    req_valid = 4'b0110;
    tick();
    chk("t3_grant1", 32'(grant), 32'd2);
    chk("t3_ready1", 32'(req_ready), 32'd2);
    tick();
    set_data(1, 8'hA1);
    req_last[1] = 1'b1;
    tick();
    chk("t3_release", 32'(grant), 32'd0);
    set_data(1, 8'hA2);
    tick();
    chk("t3_ptr_to_req2", 32'(grant), 32'd4);
    tick();
    req_valid[2] = 1'b0;
    tick();
    chk("t3_back_to_req1", 32'(grant), 32'd2);
    tick();
    req_valid = '0;
    tick();
    chk("t3_log_size", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4)
      for (int j = 0; j < 4; j++) chk("t3_log_data", 32'(wlog[j]), 32'(a4[j]));

    // Test 4: FIFO preloaded to 63, backpressure with in-flight write counted
    do_reset();
    pre_push = 1'b1;
    repeat (63) tick();
    pre_push = 1'b0;
    chk("t4_preload", 32'(fifo_cnt), 32'd63);
    set_data(0, 8'hB0);
    req_valid = 4'b0001;
    tick();
    chk("t4_ready_space", 32'(req_ready), 32'd1);
    tick();
    chk("t4_ready_inflight", 32'(req_ready), 32'd0);
    chk("t4_wr_b0", 32'(buf_in), 32'hB0);
    set_data(0, 8'hB1);
    tick();
    chk("t4_full_ready", 32'(req_ready), 32'd0);
    chk("t4_full_grant", 32'(grant), 32'd1);
    chk("t4_full_wr_en", 32'(wr_en), 32'd0);
    tick();
    chk("t4_hold_busy", 32'(busy), 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t4_resume_ready", 32'(req_ready), 32'd1);
    tick();
    chk("t4_wr_b1", 32'(buf_in), 32'hB1);
    chk("t4_ready_inflight2", 32'(req_ready), 32'd0);
    set_data(0, 8'hB2);
    req_last[0] = 1'b1;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t4_resume_ready2", 32'(req_ready), 32'd1);
    tick();
    chk("t4_wr_b2", 32'(buf_in), 32'hB2);
    chk("t4_last_release", 32'(grant), 32'd0);
    req_valid = '0;
    tick();
    chk("t4_log_size", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      chk("t4_log0", 32'(wlog[0]), 32'hB0);
      chk("t4_log1", 32'(wlog[1]), 32'hB1);
      chk("t4_log2", 32'(wlog[2]), 32'hB2);
    end
    chk("t4_fifo_full", 32'(q.size()), 32'd64);

    // Test 5: req3 withdraws before any beat
    do_reset();
    set_data(3, 8'h3F);
    req_valid = 4'b1000;
    tick();
    chk("t5_grant3", 32'(grant), 32'd8);
    req_valid = 4'b0111;
    tick();
    chk("t5_release_grant", 32'(grant), 32'd0);
    chk("t5_release_wr_en", 32'(wr_en), 32'd0);
    chk("t5_release_busy", 32'(busy), 32'd0);
    tick();
    chk("t5_next_req0", 32'(grant), 32'd1);
    req_valid = '0;
    tick();
    tick();
    chk("t5_no_write", 32'(wlog.size()), 32'd0);

    // Test 6: random traffic with per-source in-order scoreboard
    do_reset();
    sb_en  = 1'b1;
    rd_pct = pcts[0];
    for (int c = 0; c < 10000; c++) begin
      if (c % 1000 == 0) rd_pct = pcts[(c / 1000) % 4];
      rd_en = ($urandom_range(0, 99) < rd_pct);
      for (int i = 0; i < NREQ; i++) begin
        v = req_valid[i];
        if (v && !acc_q[i]) begin
          if ($urandom_range(0, 31) == 0) v = 1'b0;
        end else begin
          v = ($urandom_range(0, 3) != 0);
        end
        req_valid[i] = v;
        set_data(i, {2'(i), 6'(acc_n[i] % 64)});
        req_last[i] = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    req_valid = '0;
    rd_en = 1'b1;
    repeat (150) tick();
    for (int i = 0; i < NREQ; i++) chk("t6_count", 32'(pop_n[i]), 32'(acc_n[i]));
    chk("t6_drained", 32'(q.size()), 32'd0);
    chk("t6_progress", 32'((acc_n[0] > 100) && (acc_n[1] > 100) && (acc_n[2] > 100) && (acc_n[3] > 100)), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
